// File: rtl/count_snap_pkg.sv
// Shared constants for the count snapshot FIFO: default sizes and the
// wrap-counter width with its saturation value.
package count_snap_pkg;

    localparam int CW_DEFAULT    = 8;
    localparam int DEPTH_DEFAULT = 4;
    localparam int WRAP_W        = 8;

    localparam logic [WRAP_W-1:0] WRAP_SAT = '1;

    // Saturating increment used by the wrap-event counter.
    function automatic logic [WRAP_W-1:0] wrap_inc(input logic [WRAP_W-1:0] v);
        return (v == WRAP_SAT) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/count_snapshot_fifo_snap_fifo.sv
// snap_fifo: circular storage for snapshots. Pointers wrap naturally because
// DEPTH is a power of two. A push while full is accepted only with a pop in
// the same cycle; a pop while empty is ignored. rdata reads 0 when empty.
module snap_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok, pop_ok;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign level   = level_q;
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    // Next pointer and occupancy values from the accepted push/pop pair.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are never read while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/count_snapshot_fifo.sv
// count_snapshot_fifo: watches an upstream counter, counts its wrap events
// (saturating), and queues count snapshots on trig while en is high.
// Optional feature macro COUNT_SNAPSHOT_WRAPTAG_EN adds out_wrap, the wrap
// count (including a wrap in the capture cycle) stored with each snapshot.
// Handshake: a transfer happens on a clock edge where out_valid and
// out_ready are both 1; out_data is held while out_valid=1 and out_ready=0.
module count_snapshot_fifo
    import count_snap_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CW    = CW_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CW-1:0]            count_in,
    input  logic                     en,
    input  logic                     trig,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CW-1:0]            out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
`ifdef COUNT_SNAPSHOT_WRAPTAG_EN
    output logic [WRAP_W-1:0]        out_wrap,
`endif
    output logic [WRAP_W-1:0]        wrap_cnt
);

`ifdef COUNT_SNAPSHOT_WRAPTAG_EN
    localparam int FW = CW + WRAP_W;
`else
    localparam int FW = CW;
`endif

    logic [CW-1:0]     prev_count_q;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic              overflow_q, overflow_d;
    logic              wrap_evt, capture, push, pop, full, empty;
    logic [FW-1:0]     fifo_wdata, fifo_rdata;

    assign wrap_evt = (prev_count_q == '1) && (count_in == '0);
    assign capture  = en & trig;
    assign pop      = ~empty & out_ready;
    assign push     = capture & (~full | pop);

    // Wrap counter and sticky overflow next-state.
    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        overflow_d = overflow_q;
        if (wrap_evt) wrap_cnt_d = wrap_inc(wrap_cnt_q);
        if (capture && full && !pop) overflow_d = 1'b1;
    end

    // Previous count, wrap counter and overflow registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_count_q <= '0;
            wrap_cnt_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            prev_count_q <= count_in;
            wrap_cnt_q   <= wrap_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

`ifdef COUNT_SNAPSHOT_WRAPTAG_EN
    assign fifo_wdata = {wrap_cnt_d, count_in};
    assign out_wrap   = fifo_rdata[FW-1:CW];
`else
    assign fifo_wdata = count_in;
`endif

    snap_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign out_valid = ~empty;
    assign out_data  = fifo_rdata[CW-1:0];
    assign overflow  = overflow_q;
    assign wrap_cnt  = wrap_cnt_q;

endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Bench for count_snapshot_fifo (DEPTH=4, CW=8): directed cases followed by
// randomized traffic, compared against a queue-based reference model.
module tb_count_snapshot_fifo;

    localparam int DEPTH = 4;
    localparam int CW    = 8;

    logic          clk;
    logic          rst;
    logic [CW-1:0] count_in;
    logic          en;
    logic          trig;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_data;
    logic [2:0]    level;
    logic          overflow;
    logic [7:0]    wrap_cnt;
`ifdef COUNT_SNAPSHOT_WRAPTAG_EN
    logic [7:0]    out_wrap;
`endif

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [CW-1:0] exp_q[$];
    logic [7:0]    exp_tag_q[$];
    int            m_prev;
    int            m_wc;
    bit            m_ovf;

    count_snapshot_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .count_in  (count_in),
        .en        (en),
        .trig      (trig),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .overflow  (overflow),
`ifdef COUNT_SNAPSHOT_WRAPTAG_EN
        .out_wrap  (out_wrap),
`endif
        .wrap_cnt  (wrap_cnt)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_tag_q.delete();
        m_prev = 0;
        m_wc   = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic compare_all(input string where);
        int sz;
        sz = exp_q.size();
        check({where, ".valid"},    32'(out_valid), 32'(sz > 0));
        check({where, ".data"},     32'(out_data),  (sz > 0) ? 32'(exp_q[0]) : 32'd0);
        check({where, ".level"},    32'(level),     32'(sz));
        check({where, ".overflow"}, 32'(overflow),  32'(m_ovf));
        check({where, ".wrap_cnt"}, 32'(wrap_cnt),  32'(m_wc));
`ifdef COUNT_SNAPSHOT_WRAPTAG_EN
        check({where, ".out_wrap"}, 32'(out_wrap), (sz > 0) ? 32'(exp_tag_q[0]) : 32'd0);
`endif
    endtask

    // One clock: model evaluated from the pre-edge inputs, outputs sampled 1 ns after the edge.
    task automatic tick(input string where);
        bit do_pop, cap;
        int sz;
        sz     = exp_q.size();
        do_pop = (sz > 0) && out_ready;
        if (m_prev == 255 && count_in == 0 && m_wc < 255) m_wc++;
        cap = en && trig;
        if (do_pop) begin
            void'(exp_q.pop_front());
            void'(exp_tag_q.pop_front());
        end
        if (cap) begin
            if (sz < DEPTH || do_pop) begin
                exp_q.push_back(count_in);
                exp_tag_q.push_back(8'(m_wc));
            end else begin
                m_ovf = 1'b1;
            end
        end
        m_prev = int'(count_in);
        @(posedge clk);
        #1;
        compare_all(where);
    endtask

    // Reset pulse placed between edges; outputs must clear before any clock.
    task automatic do_reset();
        #2;
        rst  = 1'b0;
        en   = 1'b0;
        trig = 1'b0;
        #1;
        model_clear();
        compare_all("async_rst");
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drive(input logic [CW-1:0] c, input logic e, input logic t, input logic r);
        count_in  = c;
        en        = e;
        trig      = t;
        out_ready = r;
    endtask

    initial begin
        // reset for 20 ns
        rst = 1'b0;
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        model_clear();
        #20;
        compare_all("reset");
        #2;
        rst = 1'b1;

        // single capture, one-cycle latency
        drive(8'h05, 1'b1, 1'b1, 1'b0);
        tick("cap05");
        check("cap05.valid_k", 32'(out_valid), 32'd1);
        check("cap05.data_k",  32'(out_data),  32'h05);
        check("cap05.level_k", 32'(level),     32'd1);
        drive(8'h05, 1'b0, 1'b0, 1'b1);
        tick("drain05");

        // wrap detection
        drive(8'hFE, 1'b0, 1'b0, 1'b0);
        tick("sweep_fe");
        drive(8'hFF, 1'b0, 1'b0, 1'b0);
        tick("sweep_ff");
        check("sweep_ff.wrap_k", 32'(wrap_cnt), 32'd0);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        tick("sweep_00");
        check("sweep_00.wrap_k", 32'(wrap_cnt), 32'd1);
        for (int i = 0; i < 300; i++) begin
            count_in = 8'hFF;
            tick("wraps_ff");
            count_in = 8'h00;
            tick("wraps_00");
        end
        check("wrap_sat", 32'(wrap_cnt), 32'hFF);

        // overflow on a fifth capture, then ordered drain
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(8'(i), 1'b1, 1'b1, 1'b0);
            tick("fill5");
        end
        check("fill5.level_k", 32'(level),    32'd4);
        check("fill5.ovf_k",   32'(overflow), 32'd1);
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            check("drain_order", 32'(out_data), 32'(i));
            tick("drain5");
        end
        check("drain5.empty_k", 32'(out_valid), 32'd0);

        // full plus simultaneous capture and pop
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(8'(i), 1'b1, 1'b1, 1'b0);
            tick("fill4");
        end
        drive(8'h09, 1'b1, 1'b1, 1'b1);
        tick("full_swap");
        check("full_swap.level_k", 32'(level),    32'd4);
        check("full_swap.ovf_k",   32'(overflow), 32'd0);
        check("full_swap.head_k",  32'(out_data), 32'd2);
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick("swap_drain");
        check("swap_drain.empty_k", 32'(level), 32'd0);

        // en=0 masks trig
        for (int i = 0; i < 5; i++) begin
            drive(8'($urandom_range(0, 255)), 1'b0, 1'(i % 2), 1'b0);
            tick("en_off");
        end
        check("en_off.level_k", 32'(level), 32'd0);

        // two entries queued, then reset mid-stream
        for (int i = 0; i < 2; i++) begin
            drive(8'h30 + 8'(i), 1'b1, 1'b1, 1'b0);
            tick("pre_rst");
        end
        check("pre_rst.level_k", 32'(level), 32'd2);
        do_reset();
        check("mid_rst.level_k", 32'(level),     32'd0);
        check("mid_rst.valid_k", 32'(out_valid), 32'd0);

`ifdef COUNT_SNAPSHOT_WRAPTAG_EN
        // capture in the cycle of the third wrap
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(8'hFF, 1'b0, 1'b0, 1'b0);
            tick("tag_ff");
            drive(8'h00, 1'b0, 1'b0, 1'b0);
            tick("tag_00");
        end
        drive(8'hFF, 1'b0, 1'b0, 1'b0);
        tick("tag_ff3");
        drive(8'h00, 1'b1, 1'b1, 1'b0);
        tick("tag_cap");
        check("tag_cap.wrap_k", 32'(out_wrap), 32'h03);
        check("tag_cap.data_k", 32'(out_data), 32'h00);
`endif

        // randomized traffic, biased towards wraps
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0)
                count_in = (m_prev == 255) ? 8'h00 : 8'hFF;
            else
                count_in = 8'($urandom_range(0, 255));
            en        = ($urandom_range(0, 4) != 0);
            trig      = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) == 0);
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_snapshot_fifo.md
COUNT_SNAPSHOT_FIFO -- requirements
Module: count_snapshot_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-002 SHALL have parameter CW, default 8, width of the monitored count bus.
REQ-003 SHALL have port clk, input, 1, single clock; all state on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset (asserted at 0).
REQ-005 SHALL have port count_in, input, CW, count value from the upstream counter, sampled every clk.
REQ-006 SHALL have port en, input, 1, capture enable; when it is 0, trig is ignored.
REQ-007 SHALL have port trig, input, 1, single-cycle capture request.
REQ-008 SHALL have port out_valid, output, 1, head entry available.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the head entry.
REQ-010 SHALL have port out_data, output, CW, head entry count snapshot.
REQ-011 SHALL have port level, output, clog2(DEPTH)+1, current FIFO occupancy.
REQ-012 SHALL have port overflow, output, 1, sticky flag for a dropped capture.
REQ-013 SHALL have port wrap_cnt, output, 8, saturating count of count_in wrap events.

Function
REQ-014 SHALL register count_in every cycle into prev_count.
REQ-015 SHALL define a wrap event as prev_count all-ones and count_in all-zeros in the same cycle.
REQ-016 SHALL increment wrap_cnt by 1 on each wrap event and saturate it at 8'hFF.
REQ-017 SHALL define a capture as en=1 and trig=1 in a cycle, storing that cycle's count_in.
REQ-018 SHALL have a capture-to-out_valid latency of exactly 1 cycle when the FIFO is empty; there is no combinational bypass.
REQ-019 SHALL complete a transfer only in a cycle with out_valid=1 and out_ready=1, and pop the head at that clock edge.
REQ-020 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-021 SHALL drop a capture when the FIFO is full and no pop occurs, and set overflow=1.
REQ-022 SHALL accept both operations when the FIFO is full and a capture coincides with a pop; overflow and level are then unchanged.
REQ-023 SHALL not pop when the FIFO is empty; a capture in that cycle is stored normally and out_ready is ignored.
REQ-024 SHALL wrap read/write pointers modulo DEPTH.
REQ-025 SHALL keep level in the range 0..DEPTH.
REQ-026 SHALL clear overflow only by reset.

Reset
REQ-027 SHALL, on rst=0 (immediate, asynchronous), force out_valid=0, out_data=0, level=0, overflow=0, wrap_cnt=0, prev_count=0, and both pointers to 0.
REQ-028 SHALL discard all entries on reset mid-operation, including any in-flight capture.
REQ-029 SHALL treat reset deassertion as synchronous to clk, with the first capture possible on the first edge after rst=1.

Configuration
REQ-030 SHALL, with macro COUNT_SNAPSHOT_WRAPTAG_EN defined, add output out_wrap[7:0] that stores wrap_cnt alongside each snapshot, including the wrap event of the capture cycle.
REQ-031 SHALL, without COUNT_SNAPSHOT_WRAPTAG_EN, omit the out_wrap port and its storage; all other behaviour is identical.

Structure
REQ-032 SHALL place CW default, DEPTH default, and the wrap-counter width/saturation constant in package count_snap_pkg.
REQ-033 SHALL implement storage and pointers in one sub-module, snap_fifo (parameterised width and depth, push/pop/full/empty); wrap detection and capture gating live in the top.

Verification
REQ-034 SHALL check: rst=0 for 20 ns with clk period 10 ns -> all outputs 0; count_in=8'h05, en=1, trig one cycle, out_ready=0 -> next cycle out_valid=1, out_data=8'h05, level=1.
REQ-035 SHALL check: count_in sweeps 8'hFE, 8'hFF, 8'h00 -> wrap_cnt 0->1 one cycle after 8'h00; forcing 300 wraps -> wrap_cnt=8'hFF.
REQ-036 SHALL check: 5 captures (values 1..5), out_ready=0, DEPTH=4 -> level=4, overflow=1; then drain -> 1,2,3,4 in order, then out_valid=0.
REQ-037 SHALL check: FIFO full, capture of 8'h09 together with out_ready=1 -> head popped, 8'h09 stored, level=4, overflow stays 0.
REQ-038 SHALL check: en=0 with trig pulses -> level stays 0; with level=2, rst pulse low mid-stream -> level=0, out_valid=0 asynchronously.
REQ-039 SHALL check, with COUNT_SNAPSHOT_WRAPTAG_EN: capture in the cycle of the 3rd wrap -> out_wrap=8'h03 with its snapshot 8'h00.
